div_unit: RTL

//  Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU).

---
 rtl/div_unit.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/div_unit.sv
`default_nettype none
// ==========================================================================
// Module   : div_unit
// Brief    : Iterative RV32M DIV/DIVU/REM/REMU unit, restoring algorithm,
//            one quotient bit per cycle, start/done handshake with stall.
// Revision : 1.0
// ==========================================================================
module div_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall_i,
   input  logic            start_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] rem_q, rem_d;
   logic [XLEN-1:0] quo_q, quo_d;
   logic [XLEN-1:0] dvs_q, dvs_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            q_neg_q, q_neg_d;
   logic            r_neg_q, r_neg_d;
   logic            sel_rem_q, sel_rem_d;
   logic            done_q, done_d;

   logic            signed_op, a_neg, b_neg, div_zero, ovf, ge;
   logic [XLEN-1:0] a_mag, b_mag, diff, rem_fix, quo_fix;
   logic [XLEN:0]   shifted;
   logic            unused_funct3;

   // funct3[2] is always 1 for the M-extension divide group.
   assign unused_funct3 = funct3_i[2];

   assign signed_op = ~funct3_i[0];
   assign a_neg     = signed_op & rs1_i[XLEN-1];
   assign b_neg     = signed_op & rs2_i[XLEN-1];
   assign a_mag     = a_neg ? -rs1_i : rs1_i;
   assign b_mag     = b_neg ? -rs2_i : rs2_i;
   assign div_zero  = (rs2_i == '0);
   assign ovf       = signed_op && (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (&rs2_i);

   // Working remainder is XLEN+1 bits: the shifted-in bit can push it past 2^XLEN-1.
   assign shifted   = {rem_q, quo_q[XLEN-1]};
   assign ge        = (shifted >= {1'b0, dvs_q});
   assign diff      = shifted[XLEN-1:0] - dvs_q;
   assign rem_fix   = r_neg_q ? -rem_q : rem_q;
   assign quo_fix   = q_neg_q ? -quo_q : quo_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      result_d  = result_q;
      q_neg_d   = q_neg_q;
      r_neg_d   = r_neg_q;
      sel_rem_d = sel_rem_q;
      done_d    = done_q;

      if (!stall_i) begin
         done_d = 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  if (div_zero || ovf) begin
                     done_d   = 1'b1;
                     if (funct3_i[1])
                        result_d = div_zero ? rs1_i : '0;
                     else
                        result_d = div_zero ? '1 : rs1_i;
                  end else begin
                     state_d   = S_CALC;
                     cnt_d     = '0;
                     rem_d     = '0;
                     quo_d     = a_mag;
                     dvs_d     = b_mag;
                     q_neg_d   = a_neg ^ b_neg;
                     r_neg_d   = a_neg;
                     sel_rem_d = funct3_i[1];
                  end
               end
            end
            S_CALC: begin
               rem_d = ge ? diff : shifted[XLEN-1:0];
               quo_d = {quo_q[XLEN-2:0], ge};
               if (cnt_q == CW'(XLEN - 1)) begin
                  state_d = S_FIX;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            S_FIX: begin
               result_d = sel_rem_q ? rem_fix : quo_fix;
               done_d   = 1'b1;
               state_d  = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         result_q  <= '0;
         q_neg_q   <= 1'b0;
         r_neg_q   <= 1'b0;
         sel_rem_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         result_q  <= result_d;
         q_neg_q   <= q_neg_d;
         r_neg_q   <= r_neg_d;
         sel_rem_q <= sel_rem_d;
         done_q    <= done_d;
      end
   end

   assign busy_o   = (state_q != S_IDLE);
   assign done_o   = done_q;
   assign result_o = result_q;

endmodule
`default_nettype wire
